// File: rtl/q_frag_pkg.sv
// q_frag_pkg: shared mode encoding and counter-width helper for the q_frag register pipeline
package q_frag_pkg;
  typedef enum logic [1:0] {
    Q_HOLD     = 2'b00,
    Q_SHIFT    = 2'b01,
    Q_LOAD_ALL = 2'b10,
    Q_FLUSH    = 2'b11
  } q_mode_e;
  function automatic int q_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/q_frag_stage.sv
// q_frag_stage: one data+valid register of the pipeline; parity bit present under Q_FRAG_PIPE_PARITY_EN
module q_frag_stage #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             en,
  input  logic [WIDTH-1:0] d_nxt,
  input  logic             v_nxt,
`ifdef Q_FRAG_PIPE_PARITY_EN
  input  logic             p_nxt,
  output logic             qp = 1'b0,
`endif
  output logic [WIDTH-1:0] q = INIT,
  output logic             qv = 1'b0
);
  always_ff @(posedge clk)
    if (rst) begin
      q  <= INIT;
      qv <= 1'b0;
    end else if (set) q <= {WIDTH{1'b1}};
    else if (en) begin
      q  <= d_nxt;
      qv <= v_nxt;
    end
`ifdef Q_FRAG_PIPE_PARITY_EN
  // all-ones data has parity equal to the low bit of WIDTH
  always_ff @(posedge clk)
    if (rst) qp <= 1'b0;
    else if (set) qp <= ^{WIDTH{1'b1}};
    else if (en) qp <= p_nxt;
`endif
endmodule

// File: rtl/q_frag_pipe.sv
// q_frag_pipe: WIDTH x DEPTH register pipeline with valid bits, occupancy count and flags; parity via Q_FRAG_PIPE_PARITY_EN
module q_frag_pipe
  import q_frag_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}}
) (
  input  logic                        QCK,
  input  logic                        QRT,
  input  logic                        QST,
  input  logic                        QEN,
  input  logic [1:0]                  QMODE,
  input  logic                        QDS,
  input  logic [WIDTH-1:0]            QDI,
  input  logic [WIDTH-1:0]            CZI,
  input  logic                        QVI,
  output logic [WIDTH-1:0]            QZ,
  output logic                        QV,
  output logic [q_cnt_w(DEPTH)-1:0]   QCNT,
  output logic                        QFULL,
  output logic                        QEMPTY,
  output logic                        QPERR
);
  localparam int CW = q_cnt_w(DEPTH);
  q_mode_e mode;
  logic [WIDTH-1:0] d;
  logic load, adv, vin;
  logic [CW-1:0] cnt = '0;
  logic [CW-1:0] cnt_nxt;
  // chain[0] is the pipe input, chain[i+1] is the output of stage i
  logic [DEPTH:0][WIDTH-1:0] chain_d;
  logic [DEPTH:0] chain_v;
  assign mode = q_mode_e'(QMODE);
  assign d = QDS ? QDI : CZI;
  assign load = mode == Q_LOAD_ALL;
  assign adv = QEN & (mode != Q_HOLD);
  assign vin = (mode == Q_SHIFT) & QVI;
  assign chain_d[0] = d;
  assign chain_v[0] = vin;
`ifdef Q_FRAG_PIPE_PARITY_EN
  logic [DEPTH:0] chain_p;
  assign chain_p[0] = ^d;
  assign QPERR = QV & ((^QZ) != chain_p[DEPTH]);
`else
  assign QPERR = 1'b0;
`endif
  for (genvar i = 0; i < DEPTH; i++) begin : g_st
    q_frag_stage #(.WIDTH(WIDTH), .INIT(INIT)) u_st (
      .clk   (QCK),
      .rst   (QRT),
      .set   (QST),
      .en    (adv),
      .d_nxt (load ? d : chain_d[i]),
      .v_nxt (load | chain_v[i]),
`ifdef Q_FRAG_PIPE_PARITY_EN
      .p_nxt (load ? chain_p[0] : chain_p[i]),
      .qp    (chain_p[i+1]),
`endif
      .q     (chain_d[i+1]),
      .qv    (chain_v[i+1])
    );
  end
  // the dropped word's valid (QV) is what leaves; a valid QV implies cnt>=1, so no underflow
  always_comb
    cnt_nxt = load ? CW'(DEPTH) : mode == Q_HOLD ? cnt : cnt + CW'(vin) - CW'(QV);
  always_ff @(posedge QCK)
    if (QRT) cnt <= '0;
    else if (!QST && QEN) cnt <= cnt_nxt;
  assign QZ = chain_d[DEPTH];
  assign QV = chain_v[DEPTH];
  assign QCNT = cnt;
  assign QFULL = cnt == CW'(DEPTH);
  assign QEMPTY = cnt == '0;
endmodule

// File: tb/tb_q_frag_pipe.sv
// tb_q_frag_pipe: directed plus randomized checks of q_frag_pipe against an array-based reference model
module tb_q_frag_pipe;
  import q_frag_pkg::*;
  localparam int W = 8;
  localparam int DP = 4;
  logic QCK = 0, QRT = 0, QST = 0, QEN = 0, QDS = 0, QVI = 0;
  logic [1:0] QMODE = 2'b00;
  logic [W-1:0] QDI = '0, CZI = '0, QZ;
  logic QV, QFULL, QEMPTY, QPERR;
  logic [2:0] QCNT;
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] md [DP];
  bit mv [DP];
  bit mp [DP];
  q_frag_pipe #(.WIDTH(W), .DEPTH(DP), .INIT(8'h00)) dut (
    .QCK(QCK), .QRT(QRT), .QST(QST), .QEN(QEN), .QMODE(QMODE), .QDS(QDS),
    .QDI(QDI), .CZI(CZI), .QVI(QVI), .QZ(QZ), .QV(QV), .QCNT(QCNT),
    .QFULL(QFULL), .QEMPTY(QEMPTY), .QPERR(QPERR)
  );
  always #5 QCK = ~QCK;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int occupancy();
    int c = 0;
    for (int i = 0; i < DP; i++) c += mv[i];
    return c;
  endfunction
  task automatic model_edge();
    logic [W-1:0] dd = QDS ? QDI : CZI;
    if (QRT) for (int i = 0; i < DP; i++) begin md[i] = 8'h00; mv[i] = 0; mp[i] = 0; end
    else if (QST) for (int i = 0; i < DP; i++) begin md[i] = 8'hFF; mp[i] = 0; end
    else if (QEN && QMODE == Q_LOAD_ALL)
      for (int i = 0; i < DP; i++) begin md[i] = dd; mv[i] = 1; mp[i] = ^dd; end
    else if (QEN && (QMODE == Q_SHIFT || QMODE == Q_FLUSH)) begin
      for (int i = DP - 1; i > 0; i--) begin md[i] = md[i-1]; mv[i] = mv[i-1]; mp[i] = mp[i-1]; end
      md[0] = dd;
      mv[0] = (QMODE == Q_SHIFT) && QVI;
      mp[0] = ^dd;
    end
  endtask
  task automatic check_all(input string tag);
    int occ = occupancy();
    check({tag, ".qz"}, QZ, md[DP-1]);
    check({tag, ".qv"}, QV, mv[DP-1]);
    check({tag, ".cnt"}, QCNT, occ);
    check({tag, ".full"}, QFULL, occ == DP);
    check({tag, ".empty"}, QEMPTY, occ == 0);
`ifdef Q_FRAG_PIPE_PARITY_EN
    check({tag, ".perr"}, QPERR, mv[DP-1] && ((^md[DP-1]) != mp[DP-1]));
`else
    check({tag, ".perr"}, QPERR, 0);
`endif
  endtask
  task automatic cyc(input string tag, input logic rst, input logic set, input logic en,
                     input logic [1:0] mode, input logic ds, input logic [W-1:0] di,
                     input logic [W-1:0] cz, input logic vi);
    @(negedge QCK);
    QRT = rst; QST = set; QEN = en; QMODE = mode; QDS = ds; QDI = di; CZI = cz; QVI = vi;
    @(posedge QCK);
    model_edge();
    #1 check_all(tag);
  endtask
  initial begin
    for (int i = 0; i < DP; i++) begin md[i] = 8'h00; mv[i] = 0; mp[i] = 0; end
    #1 check_all("power_up");
    cyc("reset", 1, 0, 0, Q_HOLD, 0, 8'h00, 8'h00, 0);
    foreach (md[i]) cyc("fill", 0, 0, 1, Q_SHIFT, 1, 8'h11 * (i + 1), 8'h00, 1);
    check("fill_qz_lit", QZ, 8'h11);
    check("fill_full_lit", QFULL, 1);
    cyc("over", 0, 0, 1, Q_SHIFT, 1, 8'h55, 8'h00, 1);
    check("over_qz_lit", QZ, 8'h22);
    check("over_cnt_lit", QCNT, 4);
    cyc("gated", 0, 0, 0, Q_LOAD_ALL, 0, 8'h00, 8'hA5, 1);
    cyc("load", 0, 0, 1, Q_LOAD_ALL, 0, 8'h00, 8'hA5, 0);
    check("load_qz_lit", QZ, 8'hA5);
    for (int i = 0; i < 5; i++) cyc("flush", 0, 0, 1, Q_FLUSH, 1, 8'h3C, 8'h00, 1);
    check("flush_cnt_lit", QCNT, 0);
    cyc("pre_set", 0, 0, 1, Q_SHIFT, 1, 8'h01, 8'h00, 1);
    cyc("pre_set", 0, 0, 1, Q_SHIFT, 1, 8'h02, 8'h00, 1);
    cyc("set", 0, 1, 1, Q_SHIFT, 1, 8'h03, 8'h00, 1);
    check("set_qz_lit", QZ, 8'hFF);
    check("set_cnt_lit", QCNT, 2);
    cyc("rst_set", 1, 1, 1, Q_SHIFT, 1, 8'h04, 8'h00, 1);
    check("rst_set_cnt_lit", QCNT, 0);
    foreach (md[i]) cyc("bubble_in", 0, 0, 1, Q_SHIFT, 1, 8'h40 + i, 8'h00, i % 2 == 0);
    cyc("bubble_out", 0, 0, 1, Q_SHIFT, 1, 8'h50, 8'h00, 0);
    cyc("bubble_rst", 1, 0, 1, Q_SHIFT, 1, 8'h51, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc("bubble_after", 0, 0, 1, Q_SHIFT, 1, 8'h60, 8'h00, 0);
    check("bubble_after_qv_lit", QV, 0);
    for (int i = 0; i < 400; i++)
      cyc("rand", $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
          2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
`ifdef Q_FRAG_PIPE_PARITY_EN
    cyc("par_rst", 1, 0, 0, Q_HOLD, 1, 8'h00, 8'h00, 0);
    foreach (md[i]) cyc("par_fill", 0, 0, 1, Q_SHIFT, 1, 8'h07, 8'h00, 1);
    force dut.g_st[DP-1].u_st.qp = 1'b0;
    #1 check("par_err", QPERR, 1);
    release dut.g_st[DP-1].u_st.qp;
    cyc("par_clear", 1, 0, 0, Q_HOLD, 1, 8'h00, 8'h00, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
